signal_countdown_display: RTL and testbench

- Downstream consumer of the two-way traffic signal controller's `count`, `light1` and `light2` outputs.
- Computes the seconds remaining on each direction's current light and converts both values to BCD with a sequential double-dabble.
- Drives a 4-digit, time-multiplexed, active-low 7-segment display.
- Flags count/light combinations that disagree with the fixed 60-step cycle and shows dashes while they persist.

---
 rtl/signal_light_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/signal_countdown_display.sv | 180 ++++++++++++++++++
 tb/tb_signal_countdown_display.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/signal_light_pkg.sv
// Shared constants for the traffic-signal countdown display: phase boundaries,
// lamp codes, 7-segment codes and conversion FSM encodings.
package signal_light_pkg;

  localparam logic [5:0] P_A = 6'd25;
  localparam logic [5:0] P_B = 6'd30;
  localparam logic [5:0] P_C = 6'd55;
  localparam logic [5:0] P_D = 6'd60;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows blank.
  function automatic logic [6:0] digitToSeg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 6-bit value into two BCD digits in six
// clocks after a start pulse.
module bin2bcd_seq
  import signal_light_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [5:0] bin_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [5:0] bin_q, bin_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [2:0] cnt_q;
  logic [3:0] tensAdj, unitsAdj;

  always_comb begin
    tensAdj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
    unitsAdj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
    tens_d   = {tensAdj[2:0], unitsAdj[3]};
    units_d  = {unitsAdj[2:0], bin_q[5]};
    bin_d    = {bin_q[4:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      bin_q   <= bin_i;
      tens_q  <= '0;
      units_q <= '0;
      cnt_q   <= 3'd6;
    end else if (cnt_q != 3'd0) begin
      bin_q   <= bin_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      cnt_q   <= cnt_q - 3'd1;
    end
  end

  // High during the final step: the digits are complete after this edge.
  assign done_o  = (cnt_q == 3'd1);
  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/signal_countdown_display.sv
// Countdown display for the two-way signal controller: remaining seconds per
// direction, BCD conversion, fault detection and a 4-digit multiplexed scan.
module signal_countdown_display
  import signal_light_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count,
  input  logic [2:0] light1,
  input  logic [2:0] light2,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       bcd_valid
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [5:0]    count_q;
  logic [2:0]    l1_q, l2_q;
  logic [1:0]    state_q, state_d;
  logic [5:0]    lastCnt_q;
  logic [5:0]    lastLights_q;
  logic          faultPend_q, fault_q, bcdValid_q;
  bcd2_t         disp1_q, disp2_q;
  logic [5:0]    rem1, rem2;
  logic [2:0]    exp1, exp2;
  logic          faultNext, start;
  logic          done1, done2;
  logic [3:0]    tens1, units1, tens2, units2;
  logic [PW-1:0] presc_q;
  logic          scanTick;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q;
  logic [3:0]    selDigit;
  logic          selTens;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
    end else begin
      count_q <= count;
      l1_q    <= light1;
      l2_q    <= light2;
    end
  end

  always_comb begin
    exp1 = YEL;
    exp2 = RED;
    rem1 = P_D - count_q;
    rem2 = P_D - count_q;
    if (count_q < P_A) begin
      exp1 = RED;
      exp2 = GRN;
      rem1 = P_B - count_q;
      rem2 = P_A - count_q;
    end else if (count_q < P_B) begin
      exp1 = RED;
      exp2 = YEL;
      rem1 = P_B - count_q;
      rem2 = P_B - count_q;
    end else if (count_q < P_C) begin
      exp1 = GRN;
      exp2 = RED;
      rem1 = P_C - count_q;
      rem2 = P_D - count_q;
    end
    faultNext = (count_q >= P_D) || (l1_q != exp1) || (l2_q != exp2);
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE:  if (count_q != lastCnt_q || {l1_q, l2_q} != lastLights_q) state_d = LOAD;
      LOAD: begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (done1 && done2) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // lastCnt resets to an impossible count so a conversion runs right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lastCnt_q    <= 6'h3F;
      lastLights_q <= '0;
      faultPend_q  <= 1'b0;
      fault_q      <= 1'b0;
      disp1_q      <= '0;
      disp2_q      <= '0;
      bcdValid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          lastCnt_q    <= count_q;
          lastLights_q <= {l1_q, l2_q};
          faultPend_q  <= faultNext;
        end
        DONE: begin
          disp1_q    <= '{tens: tens1, units: units1};
          disp2_q    <= '{tens: tens2, units: units2};
          fault_q    <= faultPend_q;
          bcdValid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq u_conv1 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (rem1),
    .done_o  (done1),
    .tens_o  (tens1),
    .units_o (units1)
  );

  bin2bcd_seq u_conv2 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (rem2),
    .done_o  (done2),
    .tens_o  (tens2),
    .units_o (units2)
  );

  assign scanTick = (presc_q == PRESC_MAX);
  assign idx_d    = idx_q + 2'd1;

  always_comb begin
    selDigit = disp1_q.units;
    selTens  = 1'b0;
    case (idx_d)
      2'd0: begin selDigit = disp1_q.units; selTens = 1'b0; end
      2'd1: begin selDigit = disp1_q.tens;  selTens = 1'b1; end
      2'd2: begin selDigit = disp2_q.units; selTens = 1'b0; end
      default: begin selDigit = disp2_q.tens; selTens = 1'b1; end
    endcase
    seg_d = digitToSeg(selDigit);
    if (selTens && selDigit == 4'd0) seg_d = SEG_BLANK;
    if (fault_q) seg_d = SEG_DASH;
    if (!bcdValid_q) seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd3;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'hF;
    end else if (scanTick) begin
      presc_q <= '0;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= ~(4'b0001 << idx_d);
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign bcd_valid = bcdValid_q;

endmodule

// File: tb/tb_signal_countdown_display.sv
// Randomized self-checking bench for signal_countdown_display against a
// behavioural model of the 60-step signal cycle.
module tb_signal_countdown_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] count;
  logic [2:0] light1, light2;
  logic [6:0] seg;
  logic [3:0] an;
  logic       bcd_valid;

  int assertCount = 0;
  int failCount   = 0;

  logic [6:0] capSeg [4];
  logic [3:0] capMask;
  logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  signal_countdown_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .light1    (light1),
    .light2    (light2),
    .seg       (seg),
    .an        (an),
    .bcd_valid (bcd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int c, input logic [2:0] l1, input logic [2:0] l2);
    count  = 6'(c);
    light1 = l1;
    light2 = l2;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Next boundary strictly above the count, minus the count.
  function automatic int modelRem(input int c, input int dir);
    int bounds [3];
    int r;
    bit found;
    if (dir == 1) bounds = '{30, 55, 60};
    else          bounds = '{25, 30, 60};
    r = 0;
    found = 0;
    foreach (bounds[i]) begin
      if (!found && c < bounds[i]) begin
        r = bounds[i] - c;
        found = 1;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] modelLight(input int c, input int dir);
    if (dir == 1) return (c < 30) ? 3'b100 : (c < 55) ? 3'b001 : 3'b010;
    else          return (c < 25) ? 3'b001 : (c < 30) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [6:0] modelSeg(input int c, input logic [2:0] l1,
                                          input logic [2:0] l2, input int idx);
    int v;
    bit fault;
    fault = (c >= 60) || (l1 != modelLight(c, 1)) || (l2 != modelLight(c, 2));
    if (fault) return 7'h3F;
    v = modelRem(c, (idx < 2) ? 1 : 2);
    if (idx % 2 == 0) return segTab[v % 10];
    if (v / 10 == 0) return 7'h7F;
    return segTab[v / 10];
  endfunction

  task automatic captureScan();
    capMask = 4'h0;
    repeat (4 * SCAN_DIV + 2) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (an == ~(4'b0001 << i)) begin
          capSeg[i]  = seg;
          capMask[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkDisplay(input string tag, input int c,
                              input logic [2:0] l1, input logic [2:0] l2);
    captureScan();
    checkOutput({tag, "_scanmask"}, capMask, 4'hF);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_digit%0d", tag, i), capSeg[i], modelSeg(c, l1, l2, i));
  endtask

  initial begin
    int c, c0, r;
    logic [2:0] l1, l2;

    rst = 1'b1;
    applyStimulus(0, 3'b100, 3'b001);
    settle(3);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_an", an, 4'hF);
    checkOutput("rst_valid", bcd_valid, 0);

    rst = 1'b0;
    settle(4);
    checkOutput("first_tick_an", an, 4'b1110);
    checkOutput("first_tick_seg", seg, 7'h7F);
    checkOutput("first_tick_valid", bcd_valid, 0);
    settle(4);
    checkOutput("valid_before_done", bcd_valid, 0);
    settle(1);
    checkOutput("valid_after_done", bcd_valid, 1);
    checkDisplay("count0", 0, 3'b100, 3'b001);

    applyStimulus(27, 3'b100, 3'b010);
    settle(12);
    checkDisplay("count27", 27, 3'b100, 3'b010);

    applyStimulus(59, 3'b010, 3'b100);
    settle(12);
    checkDisplay("count59", 59, 3'b010, 3'b100);

    applyStimulus(0, 3'b100, 3'b001);
    settle(12);
    checkDisplay("wrap0", 0, 3'b100, 3'b001);

    applyStimulus(10, 3'b001, 3'b001);
    settle(12);
    checkDisplay("fault10", 10, 3'b001, 3'b001);

    applyStimulus(10, 3'b100, 3'b001);
    settle(12);
    checkDisplay("restore10", 10, 3'b100, 3'b001);

    applyStimulus(40, 3'b001, 3'b100);
    settle(4);
    applyStimulus(45, 3'b001, 3'b100);
    settle(25);
    checkDisplay("midshift", 45, 3'b001, 3'b100);

    applyStimulus(50, 3'b001, 3'b100);
    settle(5);
    rst = 1'b1;
    #1;
    checkOutput("midrst_seg", seg, 7'h7F);
    checkOutput("midrst_an", an, 4'hF);
    checkOutput("midrst_valid", bcd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    settle(12);
    checkOutput("postrst_valid", bcd_valid, 1);
    checkDisplay("postrst50", 50, 3'b001, 3'b100);

    for (int it = 0; it < 30; it++) begin
      c  = $urandom_range(0, 59);
      l1 = modelLight(c, 1);
      l2 = modelLight(c, 2);
      r  = $urandom_range(0, 7);
      if (r == 0) c  = $urandom_range(60, 63);
      if (r == 1) l1 = 3'($urandom_range(0, 7));
      if (r == 2) l2 = 3'($urandom_range(0, 7));
      if (r == 3) begin
        c0 = $urandom_range(0, 59);
        applyStimulus(c0, modelLight(c0, 1), modelLight(c0, 2));
        settle($urandom_range(1, 9));
      end
      applyStimulus(c, l1, l2);
      settle(25);
      checkDisplay($sformatf("rand%0d", it), c, l1, l2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
